sig_dump_monitor: RTL and testbench
===================================

Name: sig_dump_monitor

Overview:
- Synthesizable successor to the riscof bench's end-of-test logic.
- Snoops the core's data bus for mailbox writes: signature start address, signature end address and halt flag.
- Enforces a cycle timeout, then reads the signature region word by word through a memory read port and streams each word out on a valid/ready interface.
- Sits beside jedro_1_top and the data RAM. Lets FPGA and simulation runs emit signatures without hierarchical RAM peeks.

Parameters:
- DATA_WIDTH, 32: bus data width; signature word width.
- ADDR_WIDTH, 32: byte address width.
- HALT_ADDR, 32'h001F_FFF4: byte address of halt mailbox (cell MEM_SIZE_WORDS-3 for 2^19 words).
- SIG_END_ADDR, 32'h001F_FFF8: byte address of end-address mailbox.
- SIG_START_ADDR, 32'h001F_FFFC: byte address of start-address mailbox.
- TIMEOUT, 1000000: run cycles before forced dump; must be >= 1.
- CNT_WIDTH, 32: width of cycle_cnt_o.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- bus_stb_i  in  1  snooped data-bus strobe
- bus_we_i  in  4  snooped byte write enables
- bus_addr_i  in  ADDR_WIDTH  snooped byte address
- bus_wdata_i  in  DATA_WIDTH  snooped write data
- bus_ack_i  in  1  snooped slave ack
- mem_stb_o  out  1  read request to signature memory
- mem_addr_o  out  ADDR_WIDTH  word-aligned read byte address
- mem_rdata_i  in  DATA_WIDTH  read data
- mem_ack_i  in  1  read ack
- mem_err_i  in  1  read error
- sig_valid_o  out  1  signature word valid
- sig_data_o  out  DATA_WIDTH  signature word
- sig_ready_i  in  1  consumer ready
- busy_o  out  1  dump in progress
- done_o  out  1  sticky: dump finished
- timeout_o  out  1  sticky: halt not seen within TIMEOUT
- err_o  out  1  sticky: mem_err_i during dump
- cycle_cnt_o  out  CNT_WIDTH  run cycles counted

Behaviour:
- Reset values:
  - All outputs 0.
  - Mailbox registers 0.
  - State RUN.
  - Reset mid-dump aborts immediately. No further mem_stb_o; no further sig_valid_o.
- Mailbox capture:
  - A write is accepted only when bus_stb_i & bus_ack_i & (bus_we_i == 4'hF). Partial writes and reads are ignored.
  - Address match is exact on bus_addr_i. Captured bits [1:0] are forced to 0.
  - Capture is enabled only in RUN; mailbox writes in later states are ignored.
  - The last write to each mailbox wins.
- States: RUN, REQ, OUT, DONE, ERROR.
- RUN:
  - cycle_cnt_o increments every cycle.
  - Halt condition: an accepted write to HALT_ADDR with bus_wdata_i == 1. Other values do not halt.
  - On halt, or when cycle_cnt_o reaches TIMEOUT-1, latch ptr = start and go to REQ next cycle.
  - Timeout sets timeout_o.
  - Halt and timeout in the same cycle: halt wins, timeout_o stays 0.
  - If end <= start (unsigned), go straight to DONE with zero words emitted.
  - A start/end mailbox write in the halt cycle is included in the latched values.
- REQ:
  - mem_stb_o=1 and mem_addr_o=ptr, both held stable until mem_ack_i or mem_err_i.
  - If mem_err_i and mem_ack_i are both asserted, err wins.
  - On ack: register mem_rdata_i into sig_data_o, set sig_valid_o, go to OUT. mem_stb_o drops the same edge.
  - On err: set err_o, go to ERROR.
- OUT:
  - sig_valid_o and sig_data_o held stable until sig_ready_i.
  - On handshake: ptr += 4 (wraps mod 2^ADDR_WIDTH).
  - If the new ptr >= end, or ptr wrapped to 0, go to DONE. Otherwise go to REQ.
  - Throughput: at most one word per 2 cycles plus memory latency.
- DONE: done_o=1, terminal until reset.
- ERROR: err_o=1, done_o=0, terminal until reset.
- busy_o = (state == REQ or state == OUT).
- cycle_cnt_o freezes on leaving RUN. It saturates, never wraps.

Decomposition:
- Package sig_dump_pkg holds:
  - the state encoding (3-bit localparams S_RUN..S_ERROR);
  - the default mailbox byte addresses;
  - the full-word write-enable constant 4'hF.
- One natural sub-module, sig_mailbox_snoop: the bus-qualify/address-decode logic plus the three mailbox registers and the halt pulse.
- The FSM, pointer and counter stay in the top.

Test Plan:
- Halt case: write start=0x1000, end=0x1010, then halt=1; memory returns words A0..A3 with ack after 2 cycles; sig_ready_i always 1.
  -> exactly 4 words emitted in order; mem_addr_o = 0x1000, 0x1004, 0x1008, 0x100C; done_o=1; timeout_o=0.
- Timeout case: TIMEOUT=50, no halt write, start=0x20, end=0x28.
  -> timeout_o=1 after cycle_cnt_o=49; 2 words dumped; done_o=1.
- Bad writes: halt data 2, then halt with bus_we_i=4'h3 and data 1.
  -> no halt. A later full-word halt=1 triggers the dump.
- Empty region: end=start=0x100, halt.
  -> zero sig_valid_o pulses; done_o=1 two cycles after the halt write.
- Backpressure: sig_ready_i low for 5 cycles on word 1.
  -> sig_data_o stable, no new mem_stb_o; then the remaining words in order.
- Error and reset: mem_err_i on the second read.
  -> err_o=1, done_o=0, no further requests. Asserting rstn_i mid-OUT drops all outputs to 0 asynchronously.

Source files
------------

// File: rtl/sig_dump_pkg.sv
// Shared constants for the signature dump monitor: state codes, default
// mailbox byte addresses and the full-word write-enable pattern.
package sig_dump_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_RUN   = 3'd0;
  localparam state_t S_REQ   = 3'd1;
  localparam state_t S_OUT   = 3'd2;
  localparam state_t S_DONE  = 3'd3;
  localparam state_t S_ERROR = 3'd4;

  localparam logic [31:0] HALT_ADDR_DEF      = 32'h001F_FFF4;
  localparam logic [31:0] SIG_END_ADDR_DEF   = 32'h001F_FFF8;
  localparam logic [31:0] SIG_START_ADDR_DEF = 32'h001F_FFFC;

  localparam logic [3:0] WE_FULL = 4'hF;

endpackage

// File: rtl/sig_mailbox_snoop.sv
// Qualifies snooped full-word bus writes and captures the signature start/end
// mailboxes; emits a one-cycle halt pulse when the halt mailbox receives 1.
module sig_mailbox_snoop
  import sig_dump_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] HALT_ADDR      = ADDR_WIDTH'(HALT_ADDR_DEF),
  parameter logic [ADDR_WIDTH-1:0] SIG_END_ADDR   = ADDR_WIDTH'(SIG_END_ADDR_DEF),
  parameter logic [ADDR_WIDTH-1:0] SIG_START_ADDR = ADDR_WIDTH'(SIG_START_ADDR_DEF)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  en_i,
  input  logic                  bus_stb_i,
  input  logic [3:0]            bus_we_i,
  input  logic [ADDR_WIDTH-1:0] bus_addr_i,
  input  logic [DATA_WIDTH-1:0] bus_wdata_i,
  input  logic                  bus_ack_i,
  output logic [ADDR_WIDTH-1:0] start_o,
  output logic [ADDR_WIDTH-1:0] end_o,
  output logic                  halt_o
);

  logic                  wr_ok;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] start_q, start_d;
  logic [ADDR_WIDTH-1:0] end_q, end_d;

  assign wr_ok = en_i & bus_stb_i & bus_ack_i & (bus_we_i == WE_FULL);
  assign waddr = ADDR_WIDTH'(bus_wdata_i) & ~ADDR_WIDTH'(3);

  // Next-state values are exported so a mailbox write in the halt cycle counts.
  always_comb begin
    start_d = start_q;
    end_d   = end_q;
    halt_o  = 1'b0;
    if (wr_ok) begin
      if (bus_addr_i == SIG_START_ADDR) start_d = waddr;
      if (bus_addr_i == SIG_END_ADDR)   end_d   = waddr;
      if (bus_addr_i == HALT_ADDR)      halt_o  = (bus_wdata_i == DATA_WIDTH'(1));
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      start_q <= '0;
      end_q   <= '0;
    end else begin
      start_q <= start_d;
      end_q   <= end_d;
    end
  end

  assign start_o = start_d;
  assign end_o   = end_d;

endmodule

// File: rtl/sig_dump_monitor.sv
// End-of-test monitor: waits for halt or timeout, then reads the signature
// region word by word and streams it out on a valid/ready port.
module sig_dump_monitor
  import sig_dump_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] HALT_ADDR      = ADDR_WIDTH'(HALT_ADDR_DEF),
  parameter logic [ADDR_WIDTH-1:0] SIG_END_ADDR   = ADDR_WIDTH'(SIG_END_ADDR_DEF),
  parameter logic [ADDR_WIDTH-1:0] SIG_START_ADDR = ADDR_WIDTH'(SIG_START_ADDR_DEF),
  parameter int                    TIMEOUT        = 1000000,
  parameter int                    CNT_WIDTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  bus_stb_i,
  input  logic [3:0]            bus_we_i,
  input  logic [ADDR_WIDTH-1:0] bus_addr_i,
  input  logic [DATA_WIDTH-1:0] bus_wdata_i,
  input  logic                  bus_ack_i,
  output logic                  mem_stb_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i,
  input  logic                  mem_err_i,
  output logic                  sig_valid_o,
  output logic [DATA_WIDTH-1:0] sig_data_o,
  input  logic                  sig_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  timeout_o,
  output logic                  err_o,
  output logic [CNT_WIDTH-1:0]  cycle_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, ptr_inc;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  to_q, to_d;
  logic [ADDR_WIDTH-1:0] start_w, end_w;
  logic                  halt_w;

  sig_mailbox_snoop #(
    .DATA_WIDTH     (DATA_WIDTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .HALT_ADDR      (HALT_ADDR),
    .SIG_END_ADDR   (SIG_END_ADDR),
    .SIG_START_ADDR (SIG_START_ADDR)
  ) u_snoop (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .en_i        (state_q == S_RUN),
    .bus_stb_i   (bus_stb_i),
    .bus_we_i    (bus_we_i),
    .bus_addr_i  (bus_addr_i),
    .bus_wdata_i (bus_wdata_i),
    .bus_ack_i   (bus_ack_i),
    .start_o     (start_w),
    .end_o       (end_w),
    .halt_o      (halt_w)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    ptr_inc = ptr_q + ADDR_WIDTH'(4);
    case (state_q)
      S_RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
        // Halt has priority: a simultaneous timeout is not flagged.
        if (halt_w || (cnt_q == TO_LAST)) begin
          ptr_d   = start_w;
          to_d    = ~halt_w;
          state_d = (end_w > start_w) ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        if (mem_err_i) begin
          state_d = S_ERROR;
        end else if (mem_ack_i) begin
          data_d  = mem_rdata_i;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (sig_ready_i) begin
          ptr_d   = ptr_inc;
          state_d = ((ptr_inc >= end_w) || (ptr_inc == '0)) ? S_DONE : S_REQ;
        end
      end
      S_DONE, S_ERROR: ;
      default: state_d = S_ERROR;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_RUN;
      ptr_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign mem_stb_o   = (state_q == S_REQ);
  assign mem_addr_o  = ptr_q;
  assign sig_valid_o = (state_q == S_OUT);
  assign sig_data_o  = data_q;
  assign busy_o      = (state_q == S_REQ) || (state_q == S_OUT);
  assign done_o      = (state_q == S_DONE);
  assign err_o       = (state_q == S_ERROR);
  assign timeout_o   = to_q;
  assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_sig_dump_monitor.sv
// Scoreboard bench for sig_dump_monitor: directed scenarios push expected
// addresses/words; a memory responder and an output monitor check them.
module tb_sig_dump_monitor;

  localparam logic [31:0] A_HALT  = 32'h001F_FFF4;
  localparam logic [31:0] A_END   = 32'h001F_FFF8;
  localparam logic [31:0] A_START = 32'h001F_FFFC;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        bus_stb = 1'b0, bus_ack = 1'b0;
  logic [3:0]  bus_we = 4'h0;
  logic [31:0] bus_addr = '0, bus_wdata = '0;
  logic        mem_stb;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0, mem_err = 1'b0;
  logic        sig_valid, sig_ready = 1'b1;
  logic [31:0] sig_data;
  logic        busy, done, tmo, err;
  logic [31:0] cnt;

  int checks = 0, errors = 0;
  int err_at = -1, rd_idx = 0;
  logic [31:0] exp_data[$], exp_addr[$];

  always #5 clk = ~clk;

  sig_dump_monitor #(.TIMEOUT(50)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .bus_stb_i(bus_stb), .bus_we_i(bus_we), .bus_addr_i(bus_addr),
    .bus_wdata_i(bus_wdata), .bus_ack_i(bus_ack),
    .mem_stb_o(mem_stb), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
    .mem_ack_i(mem_ack), .mem_err_i(mem_err),
    .sig_valid_o(sig_valid), .sig_data_o(sig_data), .sig_ready_i(sig_ready),
    .busy_o(busy), .done_o(done), .timeout_o(tmo), .err_o(err),
    .cycle_cnt_o(cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    bus_stb = 1'b1; bus_ack = 1'b1; bus_we = we; bus_addr = a; bus_wdata = d;
    tick();
    bus_stb = 1'b0; bus_ack = 1'b0; bus_we = 4'h0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(); tick();
    exp_data.delete(); exp_addr.delete();
    rd_idx = 0; err_at = -1; sig_ready = 1'b1;
    rstn = 1'b1;
    tick();
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(done || err) && n < budget) begin tick(); n++; end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL wait_end got=busy want=done_or_err");
    end
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!sig_valid && n < budget) begin tick(); n++; end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL wait_valid got=0 want=1");
    end
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(base + 32'(4 * i));
      exp_data.push_back(32'hA000_0000 | (base + 32'(4 * i)));
    end
  endtask

  task automatic chk_drained(input string name);
    chk({name, "_addr_left"}, 64'(exp_addr.size()), 0);
    chk({name, "_data_left"}, 64'(exp_data.size()), 0);
  endtask

  // Memory: ack two cycles after the request appears; data = 0xA0000000 | addr.
  initial begin
    int wcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!rstn) begin
        mem_ack = 1'b0; mem_err = 1'b0; wcnt = 0;
      end else if (mem_ack || mem_err) begin
        mem_ack = 1'b0; mem_err = 1'b0; wcnt = 0;
      end else if (mem_stb) begin
        wcnt++;
        if (wcnt == 2) begin
          if (exp_addr.size() == 0) begin
            checks++; errors++;
            $display("FAIL mem_addr got=%0h want=no_request", mem_addr);
          end else chk("mem_addr", mem_addr, exp_addr.pop_front());
          if (rd_idx == err_at) mem_err = 1'b1;
          else begin
            mem_ack = 1'b1;
            mem_rdata = 32'hA000_0000 | mem_addr;
          end
          rd_idx++;
        end
      end else wcnt = 0;
    end
  end

  // Output monitor: words in order, stable while stalled, no overlap with requests.
  initial begin
    logic [31:0] held = '0;
    bit stall = 0;
    forever begin
      @(negedge clk);
      if (!rstn) stall = 0;
      else begin
        if (stall) begin
          chk("hold_valid", sig_valid, 1);
          chk("hold_data", sig_data, held);
        end
        if (sig_valid) chk("no_req_in_out", mem_stb, 0);
        if (sig_valid && sig_ready) begin
          if (exp_data.size() == 0) begin
            checks++; errors++;
            $display("FAIL sig_data got=%0h want=no_word", sig_data);
          end else chk("sig_data", sig_data, exp_data.pop_front());
        end
        stall = sig_valid && !sig_ready;
        held  = sig_data;
      end
    end
  end

  initial begin
    logic [31:0] c1;
    // reset state
    tick();
    chk("rst_outs", {mem_stb, sig_valid, busy, done, tmo, err}, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_data", sig_data, 0);
    chk("rst_addr", mem_addr, 0);

    // halt case: 4 words
    do_reset();
    push_words(32'h1000, 4);
    bus_wr(A_START, 32'h1000, 4'hF);
    bus_wr(A_END, 32'h1010, 4'hF);
    bus_wr(A_HALT, 32'h1, 4'hF);
    wait_end(200);
    chk("halt_done", done, 1);
    chk("halt_tmo", tmo, 0);
    chk("halt_err", err, 0);
    chk_drained("halt");

    // timeout case: TIMEOUT=50, 2 words
    do_reset();
    push_words(32'h20, 2);
    bus_wr(A_START, 32'h20, 4'hF);
    bus_wr(A_END, 32'h28, 4'hF);
    chk("pre_tmo", {tmo, busy, done}, 0);
    wait_end(300);
    chk("to_tmo", tmo, 1);
    chk("to_done", done, 1);
    chk("to_cnt", cnt, 50);
    c1 = cnt;
    tick(); tick(); tick();
    chk("to_cnt_frozen", cnt, c1);
    chk_drained("to");

    // bad writes: data 2, partial enable, read; then real halt. Start 0x202 aligns to 0x200.
    do_reset();
    bus_wr(A_START, 32'h202, 4'hF);
    bus_wr(A_END, 32'h208, 4'hF);
    bus_wr(A_HALT, 32'h2, 4'hF);
    bus_wr(A_HALT, 32'h1, 4'h3);
    bus_wr(A_HALT, 32'h1, 4'h0);
    tick(); tick(); tick();
    chk("bad_no_halt", {busy, done}, 0);
    push_words(32'h200, 2);
    bus_wr(A_HALT, 32'h1, 4'hF);
    wait_end(200);
    chk("bad_done", done, 1);
    chk("bad_tmo", tmo, 0);
    chk_drained("bad");

    // empty region
    do_reset();
    bus_wr(A_START, 32'h100, 4'hF);
    bus_wr(A_END, 32'h100, 4'hF);
    bus_wr(A_HALT, 32'h1, 4'hF);
    tick();
    chk("empty_done", done, 1);
    chk("empty_busy", busy, 0);

    // backpressure on first word
    do_reset();
    sig_ready = 1'b0;
    push_words(32'h500, 3);
    bus_wr(A_START, 32'h500, 4'hF);
    bus_wr(A_END, 32'h50C, 4'hF);
    bus_wr(A_HALT, 32'h1, 4'hF);
    wait_valid(50);
    repeat (5) tick();
    chk("bp_valid", sig_valid, 1);
    sig_ready = 1'b1;
    wait_end(200);
    chk("bp_done", done, 1);
    chk_drained("bp");

    // error on second read
    do_reset();
    err_at = 1;
    exp_addr.push_back(32'h300); exp_addr.push_back(32'h304);
    exp_data.push_back(32'hA000_0300);
    bus_wr(A_START, 32'h300, 4'hF);
    bus_wr(A_END, 32'h310, 4'hF);
    bus_wr(A_HALT, 32'h1, 4'hF);
    wait_end(200);
    chk("err_err", err, 1);
    chk("err_done", done, 0);
    begin
      logic any_stb = 1'b0;
      repeat (5) begin tick(); any_stb |= mem_stb; end
      chk("err_no_req", any_stb, 0);
    end
    chk_drained("err");

    // asynchronous reset mid-OUT
    do_reset();
    sig_ready = 1'b0;
    exp_addr.push_back(32'h400);
    bus_wr(A_START, 32'h400, 4'hF);
    bus_wr(A_END, 32'h408, 4'hF);
    bus_wr(A_HALT, 32'h1, 4'hF);
    wait_valid(50);
    #2 rstn = 1'b0;
    #1;
    chk("arst_outs", {mem_stb, sig_valid, busy, done, tmo, err}, 0);
    chk("arst_data", sig_data, 0);
    chk("arst_cnt", cnt, 0);
    tick(); tick();
    chk("arst_quiet", {mem_stb, sig_valid}, 0);
    exp_addr.delete();
    rstn = 1'b1; sig_ready = 1'b1;
    tick(); tick();
    chk("arst_run", {busy, done}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
